// File: rtl/cdc_toggle_rx.sv
// cdc_toggle_rx: receive side of a toggle-handshake crossing. Captures data_i on each request
// toggle, presents it valid/ready, and returns an ack toggle only when the consumer accepts.
`default_nettype none

module cdc_toggle_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_tgl_sync_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_tgl_o,
  output logic                  ovr_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    req_q, req_q_nxt;
  logic                    valid_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    ack_nxt;
  logic                    ovr_nxt;
  logic [CNT_WIDTH-1:0]    cnt_nxt;
  logic                    req_edge;

  assign req_edge = req_tgl_sync_i ^ req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_INIT;
      req_q      <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      ack_tgl_o  <= 1'b0;
      ovr_o      <= 1'b0;
      xfer_cnt_o <= '0;
    end else begin
      state      <= state_nxt;
      req_q      <= req_q_nxt;
      valid_o    <= valid_nxt;
      data_o     <= data_nxt;
      ack_tgl_o  <= ack_nxt;
      ovr_o      <= ovr_nxt;
      xfer_cnt_o <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_q_nxt = req_q;
    valid_nxt = valid_o;
    data_nxt  = data_o;
    ack_nxt   = ack_tgl_o;
    ovr_nxt   = ovr_o;
    cnt_nxt   = xfer_cnt_o;
    case (state)
      // Align to whatever level the request arrives at, so a reset with req=1 is not a transfer.
      ST_INIT: begin
        req_q_nxt = req_tgl_sync_i;
        valid_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (req_edge) begin
          data_nxt  = data_i;
          req_q_nxt = req_tgl_sync_i;
          valid_nxt = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // A toggle here is a sender violation: flag it, consume it, drop the word.
        if (req_edge) begin
          ovr_nxt   = 1'b1;
          req_q_nxt = req_tgl_sync_i;
        end
        if (valid_o && ready_i) begin
          valid_nxt = 1'b0;
          ack_nxt   = ~ack_tgl_o;
          cnt_nxt   = xfer_cnt_o + CNT_WIDTH'(1);
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

`default_nettype wire
